// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and a multi-cycle instruction memory (slave).
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_rdata;
  logic        imem_stall;
  logic        imem_done;
  logic        imem_err;

  modport master (
    output imem_addr, imem_rd,
    input  imem_rdata, imem_stall, imem_done, imem_err
  );

  modport slave (
    input  imem_addr, imem_rd,
    output imem_rdata, imem_stall, imem_done, imem_err
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC, multi-cycle imem handshake,
// decode stalls, branch redirects (including mid-miss), HALT and fetch errors.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_id,
  input  logic                 redirect,
  input  logic [15:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [15:0]          instruction_IFID,
  output logic [15:0]          pcAdd2_IFID,
  output logic                 inst_mem_err_IFID,
  output logic                 valid_IFID,
  output logic                 halt_fetch
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP, HALTED} state_t;
  typedef enum logic [1:0] {IF_HOLD, IF_BUBBLE, IF_LOAD, IF_ERR} ifid_op_t;

  state_t      state, state_nx;
  ifid_op_t    ifid_op;
  logic [15:0] pc, pc_nx, pc_plus2;
  logic        accept;

  assign pc_plus2       = pc + 16'd2;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  // Per-state rules pick a default IF/ID action; a done cycle in FETCH/WAIT
  // then falls through to the shared accept priority chain below.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ifid_op  = stall_id ? IF_HOLD : IF_BUBBLE;
    accept   = 1'b0;
    case (state)
      FETCH: begin
        if (imem.imem_done) begin
          accept = 1'b1;
        end else if (redirect) begin
          pc_nx   = redirect_pc;
          ifid_op = IF_BUBBLE;
        end else if (imem.imem_stall) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_done) begin
          accept = 1'b1;
        end else if (redirect) begin
          pc_nx    = redirect_pc;
          ifid_op  = IF_BUBBLE;
          state_nx = DROP;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_nx   = redirect_pc;
          ifid_op = IF_BUBBLE;
        end
        if (imem.imem_done) state_nx = FETCH;
      end
      HALTED: begin
        if (redirect) begin
          pc_nx    = redirect_pc;
          ifid_op  = IF_BUBBLE;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase

    if (accept) begin
      if (redirect) begin
        pc_nx    = redirect_pc;
        ifid_op  = IF_BUBBLE;
        state_nx = FETCH;
      end else if (stall_id) begin
        ifid_op  = IF_HOLD;
        state_nx = FETCH;
      end else if (imem.imem_err) begin
        ifid_op  = IF_ERR;
        state_nx = HALTED;
      end else begin
        ifid_op  = IF_LOAD;
        pc_nx    = pc_plus2;
        state_nx = (imem.imem_rdata[15:11] == 5'b00000) ? HALTED : FETCH;
      end
    end
  end

  always_comb begin
    imem.imem_rd = (state == FETCH);
    halt_fetch   = (state == HALTED);
  end

  // A bubble clears instruction/valid/err but leaves pcAdd2_IFID untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      instruction_IFID  <= NOP_INSTR;
      pcAdd2_IFID       <= '0;
      inst_mem_err_IFID <= 1'b0;
      valid_IFID        <= 1'b0;
    end else begin
      pc <= pc_nx;
      case (ifid_op)
        IF_BUBBLE: begin
          instruction_IFID  <= NOP_INSTR;
          inst_mem_err_IFID <= 1'b0;
          valid_IFID        <= 1'b0;
        end
        IF_LOAD: begin
          instruction_IFID  <= imem.imem_rdata;
          pcAdd2_IFID       <= pc_plus2;
          inst_mem_err_IFID <= 1'b0;
          valid_IFID        <= 1'b1;
        end
        IF_ERR: begin
          instruction_IFID  <= NOP_INSTR;
          pcAdd2_IFID       <= pc_plus2;
          inst_mem_err_IFID <= 1'b1;
          valid_IFID        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: each record drives one cycle of
// inputs, checks imem_addr/imem_rd before the edge and IF/ID/halt after it.
module tb_fetch_stage;

  typedef struct {
    logic        rst, si, rdr;
    logic [15:0] rpc;
    logic        st, dn, er;
    logic [15:0] rdata;
    logic [15:0] e_addr;
    logic        e_rd;
    logic [15:0] e_instr, e_pc2;
    logic        e_err, e_valid, e_halt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_id;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instruction_IFID, pcAdd2_IFID;
  logic        inst_mem_err_IFID, valid_IFID, halt_fetch;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage_if imem_if ();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_id          (stall_id),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .imem              (imem_if.master),
    .instruction_IFID  (instruction_IFID),
    .pcAdd2_IFID       (pcAdd2_IFID),
    .inst_mem_err_IFID (inst_mem_err_IFID),
    .valid_IFID        (valid_IFID),
    .halt_fetch        (halt_fetch)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst_i, si, rdr, input logic [15:0] rpc,
    input logic st, dn, er, input logic [15:0] rdata,
    input logic [15:0] e_addr, input logic e_rd,
    input logic [15:0] e_instr, e_pc2, input logic e_err, e_valid, e_halt);
    vec_t v;
    v.rst = rst_i; v.si = si; v.rdr = rdr; v.rpc = rpc;
    v.st = st; v.dn = dn; v.er = er; v.rdata = rdata;
    v.e_addr = e_addr; v.e_rd = e_rd; v.e_instr = e_instr; v.e_pc2 = e_pc2;
    v.e_err = e_err; v.e_valid = e_valid; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst                = v.rst;
    stall_id           = v.si;
    redirect           = v.rdr;
    redirect_pc        = v.rpc;
    imem_if.imem_stall = v.st;
    imem_if.imem_done  = v.dn;
    imem_if.imem_err   = v.er;
    imem_if.imem_rdata = v.rdata;
    #1;
    check({tag, " imem_addr"}, imem_if.imem_addr, v.e_addr);
    check({tag, " imem_rd"}, {15'd0, imem_if.imem_rd}, {15'd0, v.e_rd});
    @(posedge clk);
    #1;
    check({tag, " instruction"}, instruction_IFID, v.e_instr);
    check({tag, " pcAdd2"}, pcAdd2_IFID, v.e_pc2);
    check({tag, " err"}, {15'd0, inst_mem_err_IFID}, {15'd0, v.e_err});
    check({tag, " valid"}, {15'd0, valid_IFID}, {15'd0, v.e_valid});
    check({tag, " halt"}, {15'd0, halt_fetch}, {15'd0, v.e_halt});
  endtask

  vec_t tbl[$];
  vec_t hs[$];

  initial begin
    // reset        si rdr rpc      st dn er rdata     addr     rd instr     pc2      e  v  h
    // two hits
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4021, 16'h0000, 1, 16'h4021, 16'h0002, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4422, 16'h0002, 1, 16'h4422, 16'h0004, 0, 1, 0));
    // redirect in FETCH without done
    tbl.push_back(mk(0, 0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0004, 1, 16'h0800, 16'h0004, 0, 0, 0));
    // 3-cycle miss at 0x0010
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0010, 1, 16'h0800, 16'h0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0010, 0, 16'h0800, 16'h0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0010, 0, 16'h0800, 16'h0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h5123, 16'h0010, 0, 16'h5123, 16'h0012, 0, 1, 0));
    // redirect in 2nd WAIT cycle, data from 0x0012 dropped
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0012, 1, 16'h0800, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0012, 0, 16'h0800, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0100, 1, 0, 0, 16'h0000, 16'h0012, 0, 16'h0800, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0100, 0, 16'h0800, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h6666, 16'h0100, 0, 16'h0800, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4700, 16'h0100, 1, 16'h4700, 16'h0102, 0, 1, 0));
    // stall_id + redirect on a hit: redirect wins
    tbl.push_back(mk(0, 1, 1, 16'h0040, 0, 1, 0, 16'h7777, 16'h0102, 1, 16'h0800, 16'h0102, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4843, 16'h0040, 1, 16'h4843, 16'h0042, 0, 1, 0));
    // stall_id alone holds pc and IF/ID
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 16'h9999, 16'h0042, 1, 16'h4843, 16'h0042, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0042, 1, 16'h4843, 16'h0042, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 16'h9999, 16'h0042, 1, 16'h4843, 16'h0042, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4A00, 16'h0042, 1, 16'h4A00, 16'h0044, 0, 1, 0));
    // HALT fetched, then resumed by redirect
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0044, 1, 16'h0000, 16'h0046, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0046, 0, 16'h0800, 16'h0046, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h1234, 16'h0046, 0, 16'h0800, 16'h0046, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0046, 0, 16'h0800, 16'h0046, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4500, 16'h0020, 1, 16'h4500, 16'h0022, 0, 1, 0));
    // fetch error at 0x0008
    tbl.push_back(mk(0, 0, 1, 16'h0008, 0, 0, 0, 16'h0000, 16'h0022, 1, 16'h0800, 16'h0022, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'hABCD, 16'h0008, 1, 16'h0800, 16'h000A, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0008, 0, 16'h0800, 16'h000A, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0008, 0, 16'h0800, 16'h000A, 0, 0, 1));
    // PC wrap at 0xFFFE
    tbl.push_back(mk(0, 0, 1, 16'hFFFE, 0, 0, 0, 16'h0000, 16'h0008, 0, 16'h0800, 16'h000A, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4111, 16'hFFFE, 1, 16'h4111, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0800, 16'h0000, 0, 0, 0));

    // reset during WAIT, then redirects overwriting pc in DROP
    hs.push_back(mk(0, 0, 1, 16'h0030, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0800, 16'h0000, 0, 0, 0));
    hs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4C00, 16'h0030, 1, 16'h4C00, 16'h0032, 0, 1, 0));
    hs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0032, 1, 16'h0800, 16'h0032, 0, 0, 0));
    hs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0032, 0, 16'h0800, 16'h0000, 0, 0, 0));
    hs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4D00, 16'h0000, 1, 16'h4D00, 16'h0002, 0, 1, 0));
    hs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0002, 1, 16'h0800, 16'h0002, 0, 0, 0));
    hs.push_back(mk(0, 0, 1, 16'h0050, 1, 0, 0, 16'h0000, 16'h0002, 0, 16'h0800, 16'h0002, 0, 0, 0));
    hs.push_back(mk(0, 0, 1, 16'h0060, 1, 0, 0, 16'h0000, 16'h0050, 0, 16'h0800, 16'h0002, 0, 0, 0));
    hs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0, 16'h7F00, 16'h0060, 0, 16'h0800, 16'h0002, 0, 0, 0));
    hs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h4E00, 16'h0060, 1, 16'h4E00, 16'h0062, 0, 1, 0));

    rst                = 1'b1;
    stall_id           = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = '0;
    imem_if.imem_stall = 1'b0;
    imem_if.imem_done  = 1'b0;
    imem_if.imem_err   = 1'b0;
    imem_if.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset instruction", instruction_IFID, 16'h0800);
    check("reset pcAdd2", pcAdd2_IFID, 16'h0000);
    check("reset err", {15'd0, inst_mem_err_IFID}, 16'h0000);
    check("reset valid", {15'd0, valid_IFID}, 16'h0000);
    check("reset halt", {15'd0, halt_fetch}, 16'h0000);
    check("reset imem_addr", imem_if.imem_addr, 16'h0000);
    check("reset imem_rd", {15'd0, imem_if.imem_rd}, 16'h0001);

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
    foreach (hs[i]) step(hs[i], $sformatf("seq%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
